// File: rtl/txt_renderer_pkg.sv
// Shared types for the text renderer: FSM state, cell attribute and attribute decode.
package txt_pkg;

  typedef enum logic [2:0] {IDLE, TXT, GLYPH, LATCH, DRAW} state_t;
  typedef enum logic [1:0] {NORMAL, INVERSE, FLASH} attr_t;

  // code[7:6]: 1x normal, 00 inverse, 01 flash
  function automatic attr_t attr_dec(input logic [1:0] a);
    if (a[1])      return NORMAL;
    else if (a[0]) return FLASH;
    else           return INVERSE;
  endfunction

endpackage

// File: rtl/txt_renderer_if.sv
// VRAM write port: ready/valid pixel writes from the renderer into VRAM.
interface txt_renderer_if #(
  parameter int PIX_W   = 24,
  parameter int VRAM_AW = 16
);
  logic [VRAM_AW-1:0] vram_wadr;
  logic [PIX_W-1:0]   vram_d;
  logic               vram_we;
  logic               vram_ready;

  modport master (output vram_wadr, vram_d, vram_we, input vram_ready);
  modport slave  (input vram_wadr, vram_d, vram_we, output vram_ready);
endinterface

// File: rtl/txt_renderer.sv
// Text-mode rasteriser: text memory -> char ROM -> VRAM, one pixel line at a time.
// Optional flash attribute enabled with TXT_RENDERER_FLASH_EN.
module txt_renderer
  import txt_pkg::*;
#(
  parameter int          COLS         = 40,
  parameter int          ROWS         = 24,
  parameter int          CHAR_W       = 7,
  parameter int          CHAR_H_LOG2  = 3,
  parameter int          ADR_W        = 16,
  parameter int unsigned TXT_BASE     = 'h400,
  parameter int          PIX_W        = 24,
  parameter int          VRAM_AW      = 16,
  parameter int          FLASH_FRAMES = 16
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     start,
  input  logic [PIX_W-1:0]         fg_color,
  input  logic [PIX_W-1:0]         bg_color,
  output logic                     busy,
  output logic                     done,
  output logic [ADR_W-1:0]         txt_adr,
  input  logic [7:0]               txt_q,
  output logic [6+CHAR_H_LOG2:0]   crom_adr,
  input  logic [7:0]               crom_q,
  txt_renderer_if.master           vram
);

  localparam int LINES = ROWS << CHAR_H_LOG2;
  localparam int CW    = $clog2(COLS + 1);
  localparam int LW    = $clog2(LINES + 1);
  localparam int PW    = $clog2(CHAR_W + 1);

  state_t             state;
  logic [CW-1:0]      col;
  logic [LW-1:0]      line;
  logic [ADR_W-1:0]   row_ofs;
  logic [PW-1:0]      pix;
  logic [1:0]         code_attr;
  logic [CHAR_W-1:0]  glyph;
  logic [PIX_W-1:0]   fg, bg, on_c, off_c;
  logic               inv, accept, last_px, last_col, last_line, frame_end;
  logic               unused_bits;

  assign unused_bits = ^crom_q;

  assign accept    = (state == DRAW) && vram.vram_we && vram.vram_ready;
  assign last_px   = (pix  == PW'(CHAR_W - 1));
  assign last_col  = (col  == CW'(COLS - 1));
  assign last_line = (line == LW'(LINES - 1));
  assign frame_end = accept && last_px && last_col && last_line;

`ifdef TXT_RENDERER_FLASH_EN
  localparam int FW = $clog2(FLASH_FRAMES + 1);
  logic [FW-1:0] frame_cnt;
  logic          phase;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (frame_end) begin
      if (frame_cnt == FW'(FLASH_FRAMES - 1)) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
`else
  localparam int unused_ff = FLASH_FRAMES;
  logic phase;
  assign phase = 1'b0;
`endif

  always_comb begin
    inv = 1'b0;
    case (attr_dec(code_attr))
      INVERSE: inv = 1'b1;
      FLASH:   inv = phase;
      default: inv = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      txt_adr        <= '0;
      crom_adr       <= '0;
      vram.vram_wadr <= '0;
      vram.vram_d    <= '0;
      vram.vram_we   <= 1'b0;
      col            <= '0;
      line           <= '0;
      row_ofs        <= '0;
      pix            <= '0;
      code_attr      <= '0;
      glyph          <= '0;
      fg             <= '0;
      bg             <= '0;
      on_c           <= '0;
      off_c          <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          // busy is still high in the done cycle, so a start there is dropped
          if (start && !busy) begin
            fg             <= fg_color;
            bg             <= bg_color;
            col            <= '0;
            line           <= '0;
            row_ofs        <= '0;
            vram.vram_wadr <= '0;
            busy           <= 1'b1;
            state          <= TXT;
          end
        end
        TXT: begin
          txt_adr <= ADR_W'(TXT_BASE) + row_ofs + ADR_W'(col);
          state   <= GLYPH;
        end
        GLYPH: begin
          code_attr <= txt_q[7:6];
          crom_adr  <= {txt_q[6:0], line[CHAR_H_LOG2-1:0]};
          state     <= LATCH;
        end
        LATCH: begin
          glyph        <= crom_q[CHAR_W-1:0];
          on_c         <= inv ? bg : fg;
          off_c        <= inv ? fg : bg;
          vram.vram_d  <= (crom_q[CHAR_W-1] ^ inv) ? fg : bg;
          vram.vram_we <= 1'b1;
          pix          <= '0;
          state        <= DRAW;
        end
        DRAW: begin
          // everything holds while the write is stalled
          if (accept) begin
            vram.vram_wadr <= vram.vram_wadr + 1'b1;
            vram.vram_d    <= glyph[CHAR_W-2] ? on_c : off_c;
            glyph          <= glyph << 1;
            pix            <= pix + 1'b1;
            if (last_px) begin
              vram.vram_we <= 1'b0;
              state        <= TXT;
              if (last_col) begin
                col <= '0;
                if (last_line) begin
                  line           <= '0;
                  row_ofs        <= '0;
                  vram.vram_wadr <= '0;
                  done           <= 1'b1;
                  state          <= IDLE;
                end else begin
                  line <= line + 1'b1;
                  if (&line[CHAR_H_LOG2-1:0]) row_ofs <= row_ofs + ADR_W'(COLS);
                end
              end else begin
                col <= col + 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_txt_renderer.sv
// Directed bench for txt_renderer on a reduced 4x2 grid; memories modelled as arrays.
module tb_txt_renderer;

  localparam int COLS = 4, ROWS = 2, CHAR_W = 7, CHAR_H_LOG2 = 3;
  localparam int PIX_W = 24, VRAM_AW = 16, FF = 2;
  localparam int LINES = ROWS * 8;
  localparam int NPIX  = LINES * COLS * CHAR_W;
  localparam int FRAME = LINES * COLS * (3 + CHAR_W);
  localparam logic [15:0] BASE = 16'h400;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1, start = 1'b0;
  logic [23:0] fg_color = 24'hFFFFFF, bg_color = 24'h000000;
  logic        busy, done;
  logic [15:0] txt_adr, toff;
  logic [7:0]  txt_q, crom_q;
  logic [9:0]  crom_adr;

  txt_renderer_if #(.PIX_W(PIX_W), .VRAM_AW(VRAM_AW)) vif();

  txt_renderer #(
    .COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W), .CHAR_H_LOG2(CHAR_H_LOG2),
    .ADR_W(16), .TXT_BASE(32'h400), .PIX_W(PIX_W), .VRAM_AW(VRAM_AW), .FLASH_FRAMES(FF)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start),
    .fg_color(fg_color), .bg_color(bg_color), .busy(busy), .done(done),
    .txt_adr(txt_adr), .txt_q(txt_q), .crom_adr(crom_adr), .crom_q(crom_q),
    .vram(vif.master)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  logic [7:0]  tmem [0:COLS*ROWS-1];
  logic [7:0]  crom [0:1023];
  logic [23:0] vmem [0:NPIX-1];

  assign toff  = txt_adr - BASE;
  assign txt_q = (toff < 16'(COLS*ROWS)) ? tmem[toff] : 8'h80;
  assign crom_q = crom[crom_adr];

  int exp_adr = 0, seq_err = 0, wcnt = 0, done_cnt = 0;

  // write scoreboard: addresses must arrive 0,1,2,... within each frame
  always @(posedge CLOCK_50) begin
    if (reset || (start && !busy)) exp_adr <= 0;
    else if (vif.vram_we && vif.vram_ready) begin
      if (int'(vif.vram_wadr) != exp_adr || exp_adr >= NPIX) seq_err <= seq_err + 1;
      else vmem[exp_adr] <= vif.vram_d;
      exp_adr <= exp_adr + 1;
      wcnt    <= wcnt + 1;
    end
    if (done && !reset) done_cnt <= done_cnt + 1;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one frame; colours are scrambled after start to prove they were latched
  task automatic frame(input logic [23:0] fg, input logic [23:0] bg, input int stall_at,
                       input int restart_at, input logic [23:0] stall_d,
                       output int n, output int stalls, output int hold_err,
                       output logic [15:0] t_adr, output logic [9:0] c_adr);
    fg_color = fg; bg_color = bg;
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    n = 0; stalls = 0; hold_err = 0; t_adr = '0; c_adr = '0;
    while (!done && n < FRAME + 50) begin
      @(posedge CLOCK_50); #1;
      n++;
      start = 1'b0;
      if (n == 1) begin
        t_adr = txt_adr;
        fg_color = ~fg; bg_color = ~bg;
      end
      if (n == 2) c_adr = crom_adr;
      if (n == restart_at) start = 1'b1;
      if (vif.vram_we && int'(vif.vram_wadr) == stall_at && stalls < 5) begin
        if (vif.vram_d !== stall_d) hold_err++;
        vif.vram_ready = 1'b0;
        stalls++;
      end else begin
        vif.vram_ready = 1'b1;
      end
    end
    vif.vram_ready = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    #1;
  endtask

  logic [23:0] ea [7] = '{24'h0, 24'h0, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h0, 24'h0};
  logic [23:0] ei [7] = '{24'hFFFFFF, 24'hFFFFFF, 24'h0, 24'h0, 24'h0, 24'hFFFFFF, 24'hFFFFFF};

  initial begin
    int n, st, he, d0, w0, s0;
    logic [15:0] ta;
    logic [9:0]  ca, a;
    logic        inv_exp;

    for (int i = 0; i < COLS*ROWS; i++) tmem[i] = 8'h80;
    for (int i = 0; i < 1024; i++) crom[i] = 8'h00;
    a = {7'h41, 3'd0}; crom[a] = 8'b0011100;
    a = {7'h41, 3'd1}; crom[a] = 8'b0100010;
    a = {7'h01, 3'd0}; crom[a] = 8'b0011100;
    vif.vram_ready = 1'b1;

    // reset held 3 cycles, with start asserted throughout
    start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLOCK_50); #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_we", vif.vram_we, 0);
      chk("rst_wadr", vif.vram_wadr, 0);
    end
    reset = 1'b0; start = 1'b0;
    @(posedge CLOCK_50); #1;
    chk("start_in_rst", busy, 0);

    // single glyph, normal attribute
    tmem[0] = 8'hC1; tmem[COLS] = 8'hC1;
    d0 = done_cnt; w0 = wcnt; s0 = seq_err;
    frame(24'hFFFFFF, 24'h000000, -1, -1, 24'h0, n, st, he, ta, ca);
    chk("len", n, FRAME);
    chk("txt_adr0", ta, 16'h400);
    chk("crom_adr0", ca, 10'h208);
    for (int k = 0; k < 7; k++) chk($sformatf("norm_px%0d", k), vmem[k], ea[k]);
    chk("line1_px0", vmem[COLS*CHAR_W], 24'h0);
    chk("line1_px1", vmem[COLS*CHAR_W+1], 24'hFFFFFF);
    chk("row1_px0", vmem[8*COLS*CHAR_W], 24'h0);
    chk("row1_px2", vmem[8*COLS*CHAR_W+2], 24'hFFFFFF);
    chk("seq", seq_err - s0, 0);
    chk("wcnt", wcnt - w0, NPIX);
    chk("done_cnt", done_cnt - d0, 1);
    chk("busy_after", busy, 0);
    chk("wadr_after", vif.vram_wadr, 0);

    // inverse attribute
    tmem[0] = 8'h01; tmem[COLS] = 8'h80;
    frame(24'hFFFFFF, 24'h000000, -1, -1, 24'h0, n, st, he, ta, ca);
    for (int k = 0; k < 7; k++) chk($sformatf("inv_px%0d", k), vmem[k], ei[k]);
    chk("inv_cell1", vmem[7], 24'h0);

    // back-pressure at pixel 3
    tmem[0] = 8'hC1;
    w0 = wcnt; s0 = seq_err;
    frame(24'h123456, 24'h00ABCD, 3, -1, 24'h123456, n, st, he, ta, ca);
    chk("bp_len", n, FRAME + 5);
    chk("bp_stalls", st, 5);
    chk("bp_hold", he, 0);
    chk("bp_seq", seq_err - s0, 0);
    chk("bp_wcnt", wcnt - w0, NPIX);
    chk("bp_px0", vmem[0], 24'h00ABCD);
    chk("bp_px3", vmem[3], 24'h123456);
    chk("bp_px4", vmem[4], 24'h123456);

    // second start mid-frame is ignored
    d0 = done_cnt;
    frame(24'hFFFFFF, 24'h000000, -1, 100, 24'h0, n, st, he, ta, ca);
    repeat (20) @(posedge CLOCK_50);
    #1;
    chk("restart_len", n, FRAME);
    chk("restart_done", done_cnt - d0, 1);
    chk("restart_busy", busy, 0);

    // reset mid-frame aborts
    d0 = done_cnt;
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    repeat (499) @(posedge CLOCK_50);
    #1;
    chk("abort_busy_pre", busy, 1);
    reset = 1'b1;
    @(posedge CLOCK_50); #1;
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_we", vif.vram_we, 0);
    chk("abort_wadr", vif.vram_wadr, 0);
    chk("abort_txt", txt_adr, 0);
    repeat (FRAME) @(posedge CLOCK_50);
    #1;
    chk("abort_done", done_cnt - d0, 0);

    // flash: phase starts at 0 after the reset above
    tmem[0] = 8'h41;
    for (int f = 1; f <= 4; f++) begin
`ifdef TXT_RENDERER_FLASH_EN
      inv_exp = (f >= 3);
`else
      inv_exp = 1'b0;
`endif
      frame(24'hFFFFFF, 24'h000000, -1, -1, 24'h0, n, st, he, ta, ca);
      chk($sformatf("flash_f%0d_px0", f), vmem[0], inv_exp ? 24'hFFFFFF : 24'h0);
      chk($sformatf("flash_f%0d_px2", f), vmem[2], inv_exp ? 24'h0 : 24'hFFFFFF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/txt_renderer.md
# txt_renderer

Parametrised text-mode rasteriser. On a `start` pulse it walks a COLS×ROWS character grid and fetches each character code from text memory, then the glyph row from the character ROM. It writes every pixel of the resulting (COLS·CHAR_W)×(ROWS·CHAR_H) image into VRAM through a ready/valid write port. It sits between the text buffer / `crom` and the write side of `vram`; `vga` scans VRAM independently. It adds inverse-video and optional flash attributes, plus write-side back-pressure.

## Interface
- COLS, 40, characters per row
- ROWS, 24, character rows
- CHAR_W, 7, pixels per glyph row; glyph bit CHAR_W-1 is the leftmost pixel
- CHAR_H_LOG2, 3, log2 of glyph rows per character (CHAR_H = 8)
- ADR_W, 16, text-memory address width
- TXT_BASE, 16'h400, text-memory base address
- PIX_W, 24, VRAM pixel width
- VRAM_AW, 16, VRAM address width; must hold COLS·CHAR_W·ROWS·CHAR_H
- FLASH_FRAMES, 16, frames per flash phase; used only with TXT_RENDERER_FLASH_EN
- CLOCK_50  in  1  sole clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse that begins a frame; ignored while busy
- fg_color / bg_color  in  PIX_W  colours, sampled on accepted start
- busy  out  1  high from the cycle after start through the done cycle
- done  out  1  one-cycle pulse after the last pixel is accepted
- txt_adr  out  ADR_W  text-memory read address
- txt_q  in  8  character code, valid one cycle after txt_adr
- crom_adr  out  7+CHAR_H_LOG2  {code[6:0], glyph_line}
- crom_q  in  8  glyph row, valid one cycle after crom_adr
- vram_wadr  out  VRAM_AW  pixel write address
- vram_d  out  PIX_W  pixel colour
- vram_we  out  1  write valid
- vram_ready  in  1  write accepted when vram_we && vram_ready

## Operation
- Reset: state IDLE. busy, done and vram_we are 0. txt_adr, crom_adr, vram_wadr, vram_d, the pixel/column/line counters and the flash phase are all 0.
- State machine: IDLE → TXT → GLYPH → LATCH → DRAW, then the next cell starts at TXT, or the machine goes to IDLE at the end of the frame.
  - IDLE: on start, latch fg/bg; zero line, column and vram_wadr; go to TXT.
  - TXT: drive txt_adr = TXT_BASE + (line>>CHAR_H_LOG2)·COLS + col.
  - GLYPH: register txt_q as code; drive crom_adr = {code[6:0], line[CHAR_H_LOG2-1:0]}.
  - LATCH: register crom_q as glyph; compute the cell attribute.
  - DRAW: assert vram_we for CHAR_W accepted pixels. Pixel k uses glyph bit CHAR_W-1-k.
- Order: pixel lines 0..ROWS·CHAR_H-1 in sequence; within a line, columns 0..COLS-1. Text is re-fetched on every pixel line.
- Attribute from code[7:6]:
  - 1x: normal (bit=1 → fg, 0 → bg).
  - 00: inverse (fg and bg swapped).
  - 01: flash (see Configuration).
- vram_wadr starts at 0 and increments by 1 per accepted pixel. It is never computed by multiplication. It returns to 0 when the frame ends.
- After the last accepted pixel of the last column of the last line: pulse done, go to IDLE, drop busy.
- start while busy is ignored; start in the same cycle as reset is ignored.
- reset mid-frame aborts immediately. There is no done pulse, and the partial frame stays in VRAM.

## Timing
- The clock domain is CLOCK_50 only.
- Per cell: 3 + CHAR_W cycles with vram_ready held at 1. Each stalled cycle adds one cycle.
- With defaults and no stall, a frame is 192·40·10 = 76800 cycles from the first busy cycle. done is high in cycle 76800.
- vram_we, vram_wadr and vram_d stay stable while vram_we && !vram_ready.
- The counters advance only on acceptance.
- All outputs are registered.

## Configuration
- TXT_RENDERER_FLASH_EN defined:
  - A frame counter increments on each done.
  - The flash phase toggles every FLASH_FRAMES frames.
  - 01 cells render inverse when the phase is 1 and normal when it is 0.
  - The phase resets to 0.
- Undefined: 01 cells render as normal, and no flash counter exists.

## Structure
- Package `txt_pkg`:
  - state enum (IDLE, TXT, GLYPH, LATCH, DRAW)
  - attribute enum (NORMAL, INVERSE, FLASH)
  - 2-bit attribute decode function
- Single module. No sub-module is required.

## Test plan
- Reset: hold reset 3 cycles → busy=0, done=0, vram_we=0, vram_wadr=0 in every cycle.
- Single glyph:
  - Stimulus: code 8'hC1 at TXT_BASE, crom row 0 for 'A' = 7'b0011100, fg=FFFFFF, bg=000000, ready=1.
  - Required: first 7 writes at addr 0..6 are 0,0,FFFFFF,FFFFFF,FFFFFF,0,0.
  - Required: first txt_adr = 16'h400.
- Inverse:
  - Stimulus: code 8'h01 at cell 0 with the same glyph.
  - Required: writes at addr 0..6 are FFFFFF,FFFFFF,0,0,0,FFFFFF,FFFFFF.
- Back-pressure:
  - Stimulus: vram_ready=0 for 5 cycles at pixel 3.
  - Required: address 3 and its data are held for those cycles.
  - Required: the frame ends at 76805 cycles, and no address is skipped or duplicated.
- Frame control:
  - Stimulus: a second start at cycle 100.
  - Required: it is ignored, and exactly one done occurs at cycle 76800.
  - Stimulus: reset at cycle 500.
  - Required: IDLE next cycle, and no done.
- Flash (TXT_RENDERER_FLASH_EN, FLASH_FRAMES=2):
  - Stimulus: code 8'h41 at cell 0.
  - Required: frames 1–2 render normal, frames 3–4 render inverse.
  - Without the macro, all four frames render normal.
